// File: rtl/nn_accel_pkg.sv
// Shared types for the accelerator datapath blocks.
// Holds the read-sequencer state encoding used by mem_stream_reader.
package nn_accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs the one-cycle issue-to-output latency of the reader.
// Head is a plain register read; push while full is accepted only alongside a pop.
module skid_fifo2 #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = entry[rd_ptr];

endmodule

// File: rtl/mem_stream_reader.sv
// Walks a contiguous address range of an async-read memory and streams the words
// out over valid/ready, one word per cycle when the consumer never stalls.
module mem_stream_reader
  import nn_accel_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int BIT_SIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DEPTH-1:0]    base_addr,
  input  logic [DEPTH:0]      length,
  output logic                busy,
  output logic                done,
  output logic [DEPTH-1:0]    read_addr,
  input  logic [BIT_SIZE-1:0] read_data,
  output logic [BIT_SIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam logic [DEPTH-1:0] ADDR_ONE   = DEPTH'(1);
  localparam logic [DEPTH:0]   REMAIN_ONE = (DEPTH + 1)'(1);

  reader_state_t     state;
  reader_state_t     state_next;
  logic [DEPTH:0]    remaining;
  logic              load;
  logic              done_next;
  logic              issue;
  logic              pop;
  logic              is_last;
  logic [1:0]        fifo_count;
  logic [BIT_SIZE:0] fifo_head;

  assign pop     = out_valid && out_ready;
  assign is_last = (remaining == REMAIN_ONE);
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign issue   = (state == ISSUE) && ((fifo_count != 2'd2) || pop);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_next = ISSUE;
            load       = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue && is_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_count == 2'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      read_addr <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (load) begin
        read_addr <= base_addr;
        remaining <= length;
      end else if (issue) begin
        read_addr <= read_addr + ADDR_ONE;
        remaining <= remaining - REMAIN_ONE;
      end
    end
  end

  skid_fifo2 #(
    .WIDTH (BIT_SIZE + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue),
    .push_data ({is_last, read_data}),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign busy      = (state != IDLE);
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_head[BIT_SIZE-1:0];
  // Stale last flags left in an empty buffer must not leak out.
  assign out_last  = out_valid && fifo_head[BIT_SIZE];

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader against a queue-based reference
// of the expected word stream, with an array standing in for the memory.
module tb_mem_stream_reader;

  localparam int DEPTH    = 4;
  localparam int BIT_SIZE = 16;
  localparam int NWORDS   = 1 << DEPTH;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [DEPTH-1:0]    base_addr;
  logic [DEPTH:0]      length;
  logic                busy;
  logic                done;
  logic [DEPTH-1:0]    read_addr;
  logic [BIT_SIZE-1:0] read_data;
  logic [BIT_SIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  logic [BIT_SIZE-1:0] mem [NWORDS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign read_data = mem[read_addr];

  mem_stream_reader #(
    .DEPTH    (DEPTH),
    .BIT_SIZE (BIT_SIZE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .read_addr (read_addr),
    .read_data (read_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = rnd ? 16'($urandom) : 16'(i * 3);
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle: done=%b busy=%b, required done=0 busy=0", name, done, busy);
      end
    end
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0 from T+2; 2: random ready plus stray starts
  task automatic run_cmd(input logic [DEPTH-1:0] base, input int len, input int mode,
                         input bit timing, input string name);
    logic [BIT_SIZE-1:0] exp_data [$];
    logic                exp_last [$];
    int                  got = 0;
    int                  done_cnt = 0;
    int                  done_cyc = -1;
    int                  first_valid = -1;
    logic                prev_stall = 1'b0;
    logic [BIT_SIZE-1:0] prev_data = '0;
    logic                prev_last = 1'b0;
    logic [DEPTH-1:0]    end_addr;
    logic [DEPTH:0]      len_v;

    for (int i = 0; i < len; i++) begin
      exp_data.push_back(mem[(int'(base) + i) % NWORDS]);
      exp_last.push_back(i == len - 1);
    end
    end_addr  = DEPTH'((int'(base) + len) % NWORDS);
    len_v     = (DEPTH + 1)'(len);
    start     = 1'b1;
    base_addr = base;
    length    = len_v;

    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 2);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1 || read_addr !== base) begin
          n_fail++;
          $display("FAIL %s launch: busy=%b read_addr=%0d, required busy=1 read_addr=%0d",
                   name, busy, read_addr, base);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          n_fail++;
          $display("FAIL %s hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   name, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (exp_data.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra word: got %h, required no further words", name, out_data);
        end else begin
          logic [BIT_SIZE-1:0] ed;
          logic                el;
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          if (out_data !== ed || out_last !== el) begin
            n_fail++;
            $display("FAIL %s word %0d: data=%h last=%b, required data=%h last=%b",
                     name, got, out_data, out_last, ed, el);
          end
        end
        if (timing) begin
          n_checks++;
          if (cyc != 2 + got) begin
            n_fail++;
            $display("FAIL %s word %0d cycle: T+%0d, required T+%0d", name, got, cyc, 2 + got);
          end
        end
        got++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || read_addr !== end_addr) begin
          n_fail++;
          $display("FAIL %s at done: busy=%b valid=%b read_addr=%0d, required 0 0 %0d",
                   name, busy, out_valid, read_addr, end_addr);
        end
        break;
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy before done at T+%0d: got %b, required 1", name, cyc, busy);
      end
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        start     = 1'b1;
        base_addr = DEPTH'($urandom);
        length    = (DEPTH + 1)'($urandom_range(0, NWORDS));
      end
    end
    start = 1'b0;

    n_checks++;
    if (done_cnt != 1 || got != len) begin
      n_fail++;
      $display("FAIL %s completion: done_seen=%0d words=%0d, required done_seen=1 words=%0d",
               name, done_cnt, got, len);
    end
    if (timing) begin
      n_checks++;
      if (first_valid != 2 || done_cyc != 3 + len) begin
        n_fail++;
        $display("FAIL %s timing: first valid T+%0d done T+%0d, required T+2 and T+%0d",
                 name, first_valid, done_cyc, 3 + len);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || read_addr !== '0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset state: busy=%b done=%b addr=%0d valid=%b last=%b data=%h, required all 0",
               busy, done, read_addr, out_valid, out_last, out_data);
    end
    reset = 1'b0;
    idle_cycles(2, "post_reset");
  endtask

  task automatic test_basic();
    fill_mem(1'b0);
    run_cmd(4'd4, 5, 0, 1'b1, "basic");
    idle_cycles(2, "basic");
  endtask

  task automatic test_stall();
    run_cmd(4'd4, 5, 1, 1'b0, "stall");
    idle_cycles(2, "stall");
  endtask

  task automatic test_wrap();
    run_cmd(4'd14, 4, 0, 1'b1, "wrap");
    idle_cycles(2, "wrap");
  endtask

  task automatic test_zero_length();
    out_ready = 1'b1;
    start     = 1'b1;
    base_addr = 4'd7;
    length    = '0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len T+1: done=%b busy=%b valid=%b, required 1 0 0", done, busy, out_valid);
    end
    idle_cycles(2, "zero_len");
  endtask

  task automatic test_full();
    run_cmd(4'd0, NWORDS, 0, 1'b1, "full");
    idle_cycles(2, "full");
  endtask

  task automatic test_back_to_back();
    fill_mem(1'b1);
    run_cmd(4'd3, 3, 0, 1'b1, "b2b_first");
    run_cmd(4'd9, 2, 0, 1'b1, "b2b_second");
    idle_cycles(2, "b2b");
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      fill_mem(1'b1);
      run_cmd(DEPTH'($urandom), int'($urandom_range(1, NWORDS)), 2, 1'b0, "random");
      if ($urandom_range(0, 1) == 1) idle_cycles(1, "random");
    end
    idle_cycles(2, "random");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    start     = 1'b1;
    base_addr = 4'd2;
    length    = 5'd6;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre: valid=%b busy=%b, required 1 1", out_valid, busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || read_addr !== '0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid clear: busy=%b done=%b addr=%0d valid=%b last=%b data=%h, required all 0",
               busy, done, read_addr, out_valid, out_last, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2, "reset_mid");
    run_cmd(4'd11, 6, 0, 1'b1, "after_reset");
    idle_cycles(2, "after_reset");
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b0;
    fill_mem(1'b0);
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero_length();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side sequencer for the single-port-write / async-read `Memory` block. On a `start` command it walks a contiguous address range, captures each word returned on the memory's combinational read port, and presents the words as a valid/ready stream to downstream compute (MAC array, activation unit). A 2-entry output buffer absorbs the one-cycle issue-to-output latency, so the block sustains one word per cycle under continuous `out_ready`.

## Interface
- `DEPTH`, 8, address width; matches the attached `Memory` instance's `DEPTH`.
- `BIT_SIZE`, 16, word width; matches the attached `Memory` instance's `BIT_SIZE`.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  DEPTH  first address; sampled with `start`.
- `length`  in  DEPTH+1  word count, 0..2^DEPTH; sampled with `start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `read_addr`  out  DEPTH  drives `Memory.read_addr`.
- `read_data`  in  BIT_SIZE  from `Memory.data_out`; combinational in `read_addr`.
- `out_data`  out  BIT_SIZE  stream payload.
- `out_valid`  out  1  payload valid.
- `out_ready`  in  1  downstream accepts.
- `out_last`  out  1  qualifies the final word of a command.

## Operation
- States: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when `start`=1 and `length`!=0.
  - IDLE stays in IDLE when `start`=1 and `length`=0; `done` pulses next cycle.
  - ISSUE -> DRAIN when the last address is issued.
  - DRAIN -> IDLE when the buffer is empty after the last handshake. `done` pulses in the cycle after this transition.
- Issue rule in ISSUE: one word is issued per cycle when buffer count < 2, or when count = 2 and a pop occurs in the same cycle.
  - Issuing captures `read_data` at the current `read_addr` into the buffer tail, tagged `last` if it is the final word.
  - Issuing then increments `read_addr` and decrements the remaining count.
- `read_addr` increments modulo 2^DEPTH; ranges wrap past the top address without error.
- Buffer: 2-entry FIFO.
  - Head drives `out_data`/`out_last`; `out_valid` = (count != 0).
  - Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle leaves count unchanged.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold.
- `start` asserted outside IDLE is ignored; no queuing.
- `read_addr` holds its last value in IDLE. Memory contents may change; the block never writes.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `read_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0, buffer count 0.
- `start` at cycle T:
  - T+1: `busy`=1, `read_addr`=`base_addr`.
  - T+2: first `out_valid`=1.
- Throughput with `out_ready` held high: one word per cycle; word k appears at T+2+k.
- Command of N words, no stalls:
  - Last word handshake at T+1+N.
  - `done` pulses at T+3+N.
  - `busy` falls at T+3+N.
- `done`: exactly one cycle; a new `start` is accepted in the same cycle `done` is high.
- Reset asserted mid-command: all state clears immediately. No `done` pulse is generated, and partial data is discarded.
- Data captured in the issue cycle reflects `Memory` contents at that edge. A same-edge write to the same address returns the old word, because the read is combinational from pre-edge state.

## Structure
- Shared package `nn_accel_pkg`: state enum `reader_state_t` {IDLE, ISSUE, DRAIN}.
- Sub-module `skid_fifo2`: 2-entry FIFO parameterised by width (BIT_SIZE+1, payload plus last flag), exposing push, pop, count, and head.
- Top level holds the FSM, the address counter, and the remaining-word counter (DEPTH+1 bits).

## Test plan
- Memory preloaded `mem[a]=a*3`; base 4, length 5, `out_ready`=1 -> `out_data` 12,15,18,21,24 on consecutive cycles T+2..T+6, `out_last` only with 24, `done` at T+8.
- Same command with `out_ready` toggling 1,0,0,1,... -> same 5 words in order, each held stable while stalled, no duplicates or drops.
- DEPTH=4, base 14, length 4 -> words from addresses 14,15,0,1; `out_last` with address 1.
- length 0 -> no `out_valid`, `done` at T+1, `busy` never high.
- length 2^DEPTH (16 with DEPTH=4), base 0 -> all 16 words streamed, remaining counter does not underflow, single `done`.
- Reset asserted at T+3 of a 6-word command with `out_ready`=0 -> all outputs at reset values immediately; a subsequent `start` streams its full range correctly.
